// File: rtl/hs_pkg.sv
// Shared handshake definitions used by the master, slave and arbiter blocks.
package hs_pkg;

    localparam int unsigned HS_DATA_W  = 3;
    localparam int unsigned HS_NUM_REQ = 4;

    // Index width for n sources; never narrower than one bit.
    function automatic int unsigned hs_id_w(input int unsigned n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {HS_EMPTY, HS_FULL} hs_slot_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after base, wrapping.
module rr_pick import hs_pkg::*; #(
    parameter int unsigned NUM_REQ = HS_NUM_REQ,
    parameter int unsigned ID_W    = hs_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    base,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

    // Upper pass covers base..NUM_REQ-1, lower pass wraps to 0..base-1.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i >= 32'(base))) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output slot between NUM_REQ masters.
module hs_rr_arbiter import hs_pkg::*; #(
    parameter int unsigned NUM_REQ = HS_NUM_REQ,
    parameter int unsigned DATA_W  = HS_DATA_W,
    parameter int unsigned ID_W    = hs_id_w(NUM_REQ)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready
);

    hs_slot_e            state_q, state_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic                load;
    logic [DATA_W-1:0]   sel_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_valid),
        .base   (ptr_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // Reset gates load so no ready pulse escapes during the reset cycle.
    assign load      = pick_any && ((state_q == HS_EMPTY) || out_ready) && !sys_rst;
    assign req_ready = load ? pick_gnt : '0;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        ptr_d      = ptr_q;
        if (load) begin
            state_d    = HS_FULL;
            out_data_d = sel_data;
            out_id_d   = pick_id;
            ptr_d      = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
        end else if ((state_q == HS_FULL) && out_ready) begin
            state_d = HS_EMPTY;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= HS_EMPTY;
            out_data_q <= '0;
            out_id_q   <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = (state_q == HS_FULL);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: doc/hs_rr_arbiter.md
# hs_rr_arbiter

Round-robin arbiter that shares one valid/ready sink (the slave side of the master/slave handshake pair) between `NUM_REQ` independent masters. Each master presents `DATA_W`-bit data with valid/ready. The arbiter selects one master per cycle in rotating-priority order, registers its data into a single output slot, and presents that slot to the sink with the same valid/ready protocol. The output carries the winning master's index so the downstream logic knows the source.

## Interface

**Parameters**

- `NUM_REQ`, default 4: number of requesting masters. Legal range is 2..8.
- `DATA_W`, default 3: payload width. Matches the master/slave data bus.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the source index. Minimum 1.

**Ports** (clock and reset first)

- `sys_clk` in, 1: the single clock. All logic is rising-edge.
- `sys_rst` in, 1: reset. Synchronous and active-high.
- `req_valid` in, `NUM_REQ`: per-master valid. Bit i belongs to master i.
- `req_data` in, `NUM_REQ*DATA_W`: per-master payload. Master i uses bits `[i*DATA_W +: DATA_W]`.
- `req_ready` out, `NUM_REQ`: per-master ready. At most one bit is high in any cycle.
- `out_valid` out, 1: the output slot holds data.
- `out_data` out, `DATA_W`: payload in the output slot.
- `out_id` out, `ID_W`: index of the master whose data is in the slot.
- `out_ready` in, 1: the sink accepts the slot this cycle.

## Operation

**Reset values.** While `sys_rst` is high:
- `out_valid`=0, `out_data`=0, `out_id`=0.
- Round-robin pointer `ptr`=0.
- `req_ready` is all zero, regardless of `req_valid`.

**Slot state machine.** Two states:
- EMPTY (`out_valid`=0).
- FULL (`out_valid`=1).

**Load condition.** `load = any(req_valid) & (EMPTY | out_ready)`.

**Winner selection.** The winner `w` is the first i with `req_valid[i]=1`, searched in the order `ptr`, `ptr+1`, …, `NUM_REQ-1`, 0, …, `ptr-1` (modulo `NUM_REQ`).

**Ready generation.** `req_ready[w] = load`. Every other bit of `req_ready` is 0. `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `ptr`.

**On a load:**
- `out_data` <= `req_data[w]`, `out_id` <= `w`, `out_valid` <= 1.
- `ptr` <= `(w+1) mod NUM_REQ`.

**Transitions:**
- EMPTY -> FULL on load.
- FULL -> FULL when `out_ready` is high and a load occurs. This is back-to-back operation at one transfer per cycle.
- FULL -> EMPTY when `out_ready` is high and no request is valid.
- FULL with `out_ready`=0: hold the slot. `out_valid`, `out_data` and `out_id` must not change, and `req_ready` is all zero.

**Pointer and arbitration rules.**
- `ptr` changes only on a load.
- Arbitration is recomputed every cycle; no grant is locked. A master that drops valid before its handshake simply loses its turn.
- A master that holds valid is served within `NUM_REQ` loads (fairness bound).
- A single active master is served every cycle, provided the sink is always ready.

**Reset mid-operation.** A slot that is FULL and not yet taken is discarded. No `req_ready` pulse is issued in the reset cycle.

## Timing

- Latency from request to output: 1 cycle. A handshake with master i in cycle n gives `out_valid`=1 with its data in cycle n+1.
- Throughput: 1 transfer per cycle when `out_ready` is held at 1.
- No combinational path from `req_data` to any output.
- `out_ready` reaches `req_ready` combinationally (pass-through refill). There is no path from `out_ready` to `out_valid`/`out_data` within the same cycle.
- Simultaneous drain and refill in the same cycle is the required behaviour. The slot never shows a bubble when requests are pending.

## Structure

- Shared package `hs_pkg`:
  - `HS_DATA_W` = 3.
  - Default `NUM_REQ`.
  - Id-width helper function.
  - The slot state enum `{HS_EMPTY, HS_FULL}`.
  - These are shared with the master and slave blocks.
- Sub-module `rr_pick`: purely combinational rotating-priority picker.
  - Inputs: `req[NUM_REQ]`, `base[ID_W]`.
  - Outputs: `gnt` (one-hot), `gnt_id`, `any`.
- The top level holds `ptr`, the output slot registers and the ready logic.

## Test plan

1. **Reset.** Assert `sys_rst` for 2 cycles with `req_valid`=4'b1111 -> `req_ready`=0, `out_valid`=0, `out_id`=0 throughout.
2. **Full rotation.** `req_valid`=4'b1111, data i=i+1, `out_ready`=1 -> `req_ready` one-hot rotates 0,1,2,3,0. Output shows `out_id` 0,1,2,3 with data 1,2,3,4, one per cycle, starting 1 cycle after the first handshake.
3. **Backpressure.** Slot FULL with id 2 and data 5, `out_ready`=0 for 3 cycles with all requests valid -> `out_data`=5 and `out_id`=2 stable, `req_ready`=0. When `out_ready` rises, master 3 is granted in that same cycle.
4. **Pointer skip.** `ptr`=1, `req_valid`=4'b0001 -> master 0 wins, and afterwards `ptr`=1. Then `req_valid`=4'b0011 -> master 1 wins.
5. **Single master streaming.** Only master 2 valid, `out_ready`=1, data 7,6,5 -> three back-to-back transfers with `out_id`=2 and no bubble. After the last one, `out_valid` falls 1 cycle after valid drops.
6. **Reset mid-operation.** Slot FULL, `out_ready`=0, `sys_rst` pulsed for 1 cycle -> `out_valid`=0 next cycle, and `ptr`=0 so the next grant goes to the lowest valid index.
